// File: rtl/lstm_mem_pkg.sv
// Shared parameters and reader state encoding for the LSTM data memory path.
// Also holds the window legality rule used when a read window is requested.
package lstm_mem_pkg;

    localparam int          LSTM_DATA_WIDTH = 32;
    localparam int          LSTM_ADDR_WIDTH = 7;
    localparam int unsigned LSTM_MEM_SIZE   = 100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    // A window is legal when it is non-empty and stays inside the populated BRAM.
    function automatic logic window_fits(input int unsigned addr,
                                         input int unsigned n,
                                         input int unsigned mem_size);
        return (n != 0) && (addr + n <= mem_size);
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO that absorbs BRAM read returns in front of the stream port.
// Overflow is prevented upstream by the reader's credit check.
module bram_rd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed once count marks it valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/data_bram_reader.sv
// Streams a contiguous window of data_global_bram words onto a valid/ready port,
// hiding the BRAM's one-cycle read latency behind a 4-entry return FIFO.
module data_bram_reader
    import lstm_mem_pkg::*;
#(
    parameter int          DATA_WIDTH = LSTM_DATA_WIDTH,
    parameter int          ADDR_WIDTH = LSTM_ADDR_WIDTH,
    parameter int unsigned MEM_SIZE   = LSTM_MEM_SIZE,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_t state;
    rd_state_t state_nxt;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   iss_left;
    logic [ADDR_WIDTH:0]   ret_left;
    logic                  ret_valid;
    logic                  rejected;

    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic [CNT_W:0]        committed;

    logic accept;
    logic reject;
    logic issue;
    logic beat;
    logic credit_ok;

    // Words owed to the FIFO: already buffered, in the re stage, or in the return stage.
    assign committed = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, re}
                     + {{CNT_W{1'b0}}, ret_valid};
    assign credit_ok = committed < (CNT_W + 1)'(FIFO_DEPTH);

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head : '0;
    assign m_last  = m_valid && (ret_left == (ADDR_WIDTH + 1)'(1));
    assign beat    = m_valid && m_ready;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_DONE) && rejected;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (window_fits(32'(start_addr), 32'(len), MEM_SIZE)) begin
                        accept    = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        reject    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (iss_left == (ADDR_WIDTH + 1)'(1)) state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (beat && m_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re        <= 1'b0;
            rd_addr   <= '0;
            next_addr <= '0;
            iss_left  <= '0;
            ret_left  <= '0;
            ret_valid <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            re        <= issue;
            ret_valid <= re;
            if (issue) begin
                rd_addr   <= next_addr;
                next_addr <= next_addr + 1'b1;
                iss_left  <= iss_left - 1'b1;
            end
            if (accept) begin
                next_addr <= start_addr;
                iss_left  <= len;
                ret_left  <= len;
                rejected  <= 1'b0;
            end
            if (reject) rejected <= 1'b1;
            if (beat)   ret_left <= ret_left - 1'b1;
        end
    end

    bram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ret_valid),
        .push_data (bram_dout),
        .pop       (beat),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_data_bram_reader.sv
// Scoreboard bench for data_bram_reader: a BRAM model with mem[i]=i+0x100, randomized
// windows and ready patterns, expectations queued at stimulus time and checked by a monitor.
module tb_data_bram_reader;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int MS = 100;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] rd_addr;
    logic          re;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    data_bram_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (MS),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .rd_addr    (rd_addr),
        .re         (re),
        .bram_dout  (bram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // BRAM model: one-cycle registered read.
    logic [DW-1:0] bram [MS];
    initial for (int i = 0; i < MS; i++) bram[i] = DW'(32'h100 + i);
    always @(posedge clk) if (re && int'(rd_addr) < MS) bram_dout <= bram[rd_addr];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    logic  done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int re_cnt   = 0;
    int out_cnt  = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Ready driver: 0 = always ready, 1 = repeating 1,0,0, 2 = random.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       begin m_ready = (phase == 0); phase = (phase + 1) % 3; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares stream beats and done/err pulses against the queued expectations.
    always @(negedge clk) begin : monitor
        beat_t e;
        logic  exp_err;
        if (!rst_n) begin
            out_cnt = 0;
        end else begin
            if (re) begin
                re_cnt++;
                out_cnt++;
                check("outstanding_le_4", 32'(out_cnt <= FD), 32'd1);
                check("rd_addr_in_range", 32'(int'(rd_addr) < MS), 32'd1);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat", $sformatf("got data 0x%0h, expected no beat", m_data));
                end else begin
                    e = exp_q[0];
                    check("m_data", m_data, e.data);
                    check("m_last", 32'(m_last), 32'(e.last));
                    if (m_ready) void'(exp_q.pop_front());
                end
                if (m_ready) out_cnt--;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected_done", "got done=1, expected no done");
                end else begin
                    exp_err = done_q.pop_front();
                    check("err_at_done", 32'(err), 32'(exp_err));
                end
            end else if (err) begin
                fail_now("err_without_done", "got err=1 with done=0");
            end
        end
    end

    function automatic bit fits(input int addr, input int n);
        return (n != 0) && (addr + n <= MS);
    endfunction

    task automatic launch(input int addr, input int n, input bit queue_expect);
        if (queue_expect) begin
            if (fits(addr, n)) begin
                for (int i = 0; i < n; i++) begin
                    beat_t b;
                    b.data = DW'(32'h100 + addr + i);
                    b.last = (i == n - 1);
                    exp_q.push_back(b);
                end
                done_q.push_back(1'b0);
            end else begin
                done_q.push_back(1'b1);
            end
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(addr);
        len        = (AW + 1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from the accepting edge to the done cycle; bounded.
    task automatic wait_done(output int cyc, input bit restart_in_done);
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        if (cyc >= 1000) begin
            fail_now("done_timeout", "no done within 1000 cycles");
        end else if (restart_in_done) begin
            start      = 1'b1;
            start_addr = AW'(0);
            len        = (AW + 1)'(4);
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("start_in_done_ignored", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic run_window(input int addr, input int n, input int mode,
                              input bit check_lat, input bit restart_in_done);
        int cyc;
        int re0;
        ready_mode = mode;
        re0 = re_cnt;
        launch(addr, n, 1'b1);
        wait_done(cyc, restart_in_done);
        if (check_lat) check("done_latency", 32'(cyc), fits(addr, n) ? 32'(n + 3) : 32'd0);
        check("re_count", 32'(re_cnt - re0), fits(addr, n) ? 32'(n) : 32'd0);
        check("beats_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_re", 32'(re), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        int cyc;
        int re0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Full window at full rate, with a start pulse in the DONE cycle.
        run_window(0, 100, 0, 1'b1, 1'b1);
        // Backpressure with ready pattern 1,0,0.
        run_window(10, 8, 1, 1'b0, 1'b0);
        // Rejected windows and a single word at the top of memory.
        run_window(95, 10, 0, 1'b1, 1'b0);
        run_window(3, 0, 0, 1'b1, 1'b0);
        run_window(99, 1, 0, 1'b1, 1'b0);
        run_window(90, 10, 2, 1'b0, 1'b0);

        // Start during RUN must be ignored.
        ready_mode = 2;
        re0 = re_cnt;
        launch(20, 30, 1'b1);
        repeat (5) @(posedge clk);
        launch(0, 5, 1'b0);
        wait_done(cyc, 1'b0);
        check("ignored_start_re_count", 32'(re_cnt - re0), 32'd30);
        check("ignored_start_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a window.
        ready_mode = 0;
        launch(0, 60, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        exp_q.delete();
        done_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done), 32'd0);
        end
        run_window(40, 10, 0, 1'b1, 1'b0);

        // Randomized windows and ready behaviour.
        for (int t = 0; t < 14; t++) begin
            int a;
            int n;
            int mode;
            a    = int'($urandom_range(0, 99));
            n    = int'($urandom_range(0, 40));
            mode = int'($urandom_range(0, 2));
            run_window(a, n, mode, mode == 0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_empty", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
